// File: rtl/pdp8_pkg.sv
// Shared PDP-8 definitions used by the memory arbiter: FSM encoding,
// read-owner tag and the default fetch starvation limit.
package pdp8_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_ISSUE = 2'd1,
      WR_ISSUE = 2'd2,
      RD_DATA  = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_IFU  = 1'b0,
      OWN_EXEC = 1'b1
   } arb_owner_e;

   localparam int ARB_STARVE_LIMIT = 4;

endpackage

// File: rtl/pdp_arb_starve_ctr.sv
// Saturating count of arbitration cycles fetch has lost in a row; starved
// flags that fetch must win the next arbitration it requests in.
module pdp_arb_starve_ctr
   import pdp8_pkg::*;
#(
   parameter int LIMIT = ARB_STARVE_LIMIT,
   parameter int CW    = $clog2(LIMIT + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] cnt,
   output logic          starved
);

   assign starved = (cnt == CW'(LIMIT));

   // Clear has priority; increment saturates at LIMIT; otherwise hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !starved) begin
         cnt <= cnt + CW'(1);
      end else begin
         cnt <= cnt;
      end
   end

endmodule

// File: rtl/pdp_mem_arbiter.sv
// Shares the single memory_pdp port between instruction fetch (read-only)
// and EXEC (read/write), one registered access at a time.
module pdp_mem_arbiter
   import pdp8_pkg::*;
#(
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 12,
   parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ifu_rd_req,
   input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
   output logic                  ifu_gnt,
   output logic                  ifu_rd_valid,
   output logic [DATA_WIDTH-1:0] ifu_rd_data,
   input  logic                  exec_rd_req,
   input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
   input  logic                  exec_wr_req,
   input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
   input  logic [DATA_WIDTH-1:0] exec_wr_data,
   output logic                  exec_gnt,
   output logic                  exec_rd_valid,
   output logic [DATA_WIDTH-1:0] exec_rd_data,
   output logic                  mem_rd_req,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   output logic                  mem_wr_req,
   output logic [ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  proto_err
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   arb_state_e    state;
   arb_state_e    state_nxt;
   arb_owner_e    owner;
   logic [CW-1:0] starve_cnt;
   logic          starved;
   logic          arb_cycle;
   logic          win_ifu;
   logic          win_wr;
   logic          win_exrd;
   logic          cnt_inc;
   logic          cnt_clr;

   pdp_arb_starve_ctr #(
      .LIMIT (STARVE_LIMIT),
      .CW    (CW)
   ) u_starve (
      .clk     (clk),
      .reset   (reset),
      .inc     (cnt_inc),
      .clr     (cnt_clr),
      .cnt     (starve_cnt),
      .starved (starved)
   );

   // Priority pick; requests are ignored while an access is being issued.
   always_comb begin
      arb_cycle = (state == IDLE) || (state == RD_DATA);
      win_ifu   = 1'b0;
      win_wr    = 1'b0;
      win_exrd  = 1'b0;
      if (arb_cycle) begin
         if (starved && ifu_rd_req) begin
            win_ifu = 1'b1;
         end else if (exec_wr_req) begin
            win_wr = 1'b1;
         end else if (exec_rd_req) begin
            win_exrd = 1'b1;
         end else if (ifu_rd_req) begin
            win_ifu = 1'b1;
         end else begin
            win_ifu = 1'b0;
         end
      end else begin
         win_ifu = 1'b0;
      end
      cnt_inc = arb_cycle && ifu_rd_req && (win_wr || win_exrd);
      cnt_clr = arb_cycle && (!ifu_rd_req || win_ifu);
   end

   // Next-state selection.
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE, RD_DATA: begin
            if (win_wr) begin
               state_nxt = WR_ISSUE;
            end else if (win_exrd || win_ifu) begin
               state_nxt = RD_ISSUE;
            end else begin
               state_nxt = IDLE;
            end
         end
         RD_ISSUE: state_nxt = RD_DATA;
         WR_ISSUE: state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Registered grants, memory strobes, owner and read-valid steering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         owner         <= OWN_IFU;
         ifu_gnt       <= 1'b0;
         exec_gnt      <= 1'b0;
         mem_rd_req    <= 1'b0;
         mem_rd_addr   <= '0;
         mem_wr_req    <= 1'b0;
         mem_wr_addr   <= '0;
         mem_wr_data   <= '0;
         ifu_rd_valid  <= 1'b0;
         exec_rd_valid <= 1'b0;
         proto_err     <= 1'b0;
      end else begin
         state       <= state_nxt;
         ifu_gnt     <= win_ifu;
         exec_gnt    <= win_wr || win_exrd;
         mem_rd_req  <= win_ifu || win_exrd;
         mem_rd_addr <= win_ifu ? ifu_rd_addr : (win_exrd ? exec_rd_addr : '0);
         mem_wr_req  <= win_wr;
         mem_wr_addr <= win_wr ? exec_wr_addr : '0;
         mem_wr_data <= win_wr ? exec_wr_data : '0;
         if (win_ifu) begin
            owner <= OWN_IFU;
         end else if (win_exrd) begin
            owner <= OWN_EXEC;
         end else begin
            owner <= owner;
         end
         ifu_rd_valid  <= (state == RD_ISSUE) && (owner == OWN_IFU);
         exec_rd_valid <= (state == RD_ISSUE) && (owner == OWN_EXEC);
         proto_err     <= proto_err | (exec_rd_req & exec_wr_req);
      end
   end

   assign ifu_rd_data  = ifu_rd_valid  ? mem_rd_data : '0;
   assign exec_rd_data = exec_rd_valid ? mem_rd_data : '0;

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// Directed self-checking bench for pdp_mem_arbiter with a small read-only
// memory model that returns data the cycle after each read strobe.
module tb_pdp_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        ifu_rd_req;
   logic [11:0] ifu_rd_addr;
   logic        ifu_gnt;
   logic        ifu_rd_valid;
   logic [11:0] ifu_rd_data;
   logic        exec_rd_req;
   logic [11:0] exec_rd_addr;
   logic        exec_wr_req;
   logic [11:0] exec_wr_addr;
   logic [11:0] exec_wr_data;
   logic        exec_gnt;
   logic        exec_rd_valid;
   logic [11:0] exec_rd_data;
   logic        mem_rd_req;
   logic [11:0] mem_rd_addr;
   logic        mem_wr_req;
   logic [11:0] mem_wr_addr;
   logic [11:0] mem_wr_data;
   logic [11:0] mem_rd_data = 12'o0;
   logic        proto_err;

   int n_checks = 0;
   int n_fail   = 0;

   pdp_mem_arbiter dut (
      .clk           (clk),
      .reset         (reset),
      .ifu_rd_req    (ifu_rd_req),
      .ifu_rd_addr   (ifu_rd_addr),
      .ifu_gnt       (ifu_gnt),
      .ifu_rd_valid  (ifu_rd_valid),
      .ifu_rd_data   (ifu_rd_data),
      .exec_rd_req   (exec_rd_req),
      .exec_rd_addr  (exec_rd_addr),
      .exec_wr_req   (exec_wr_req),
      .exec_wr_addr  (exec_wr_addr),
      .exec_wr_data  (exec_wr_data),
      .exec_gnt      (exec_gnt),
      .exec_rd_valid (exec_rd_valid),
      .exec_rd_data  (exec_rd_data),
      .mem_rd_req    (mem_rd_req),
      .mem_rd_addr   (mem_rd_addr),
      .mem_wr_req    (mem_wr_req),
      .mem_wr_addr   (mem_wr_addr),
      .mem_wr_data   (mem_wr_data),
      .mem_rd_data   (mem_rd_data),
      .proto_err     (proto_err)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] rom(input logic [11:0] a);
      case (a)
         12'o0200: rom = 12'o7200;
         12'o0201: rom = 12'o4567;
         12'o0202: rom = 12'o2222;
         12'o0203: rom = 12'o5555;
         12'o0204: rom = 12'o6666;
         12'o0300: rom = 12'o1111;
         12'o0301: rom = 12'o3333;
         default:  rom = 12'o0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (mem_rd_req) mem_rd_data <= rom(mem_rd_addr);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0o expected %0o", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ctl"}, 32'({ifu_gnt, ifu_rd_valid, exec_gnt, exec_rd_valid,
                                mem_rd_req, mem_wr_req, proto_err}), 32'd0);
      check({tag, "_bus"}, 32'(mem_rd_addr | mem_wr_addr | mem_wr_data), 32'd0);
      check({tag, "_rdd"}, 32'(ifu_rd_data | exec_rd_data), 32'd0);
   endtask

   int   ngr;
   logic gw [5];
   logic seen_valid;

   initial begin
      reset        = 1'b1;
      ifu_rd_req   = 1'b0;
      ifu_rd_addr  = 12'o0;
      exec_rd_req  = 1'b0;
      exec_rd_addr = 12'o0;
      exec_wr_req  = 1'b0;
      exec_wr_addr = 12'o0;
      exec_wr_data = 12'o0;
      #1;
      check_quiet("reset");
      step();
      step();
      reset = 1'b0;
      step();
      check_quiet("post_reset");

      // Fetch-only read
      ifu_rd_req  = 1'b1;
      ifu_rd_addr = 12'o0200;
      step();
      check("t1_ifu_gnt", 32'(ifu_gnt), 32'd1);
      check("t1_mem_rd_req", 32'(mem_rd_req), 32'd1);
      check("t1_mem_rd_addr", 32'(mem_rd_addr), 32'o200);
      check("t1_exec_gnt", 32'(exec_gnt), 32'd0);
      ifu_rd_req = 1'b0;
      step();
      check("t1_ifu_valid", 32'(ifu_rd_valid), 32'd1);
      check("t1_ifu_data", 32'(ifu_rd_data), 32'o7200);
      check("t1_exec_quiet", 32'({exec_rd_valid, exec_gnt}), 32'd0);
      check("t1_exec_data", 32'(exec_rd_data), 32'd0);
      step();
      check("t1_valid_pulse", 32'(ifu_rd_valid), 32'd0);
      check("t1_data_gated", 32'(ifu_rd_data), 32'd0);

      // EXEC write and fetch read together
      exec_wr_req  = 1'b1;
      exec_wr_addr = 12'o0050;
      exec_wr_data = 12'o1234;
      ifu_rd_req   = 1'b1;
      ifu_rd_addr  = 12'o0201;
      step();
      check("t2_wr_req", 32'(mem_wr_req), 32'd1);
      check("t2_wr_addr", 32'(mem_wr_addr), 32'o50);
      check("t2_wr_data", 32'(mem_wr_data), 32'o1234);
      check("t2_gnts", 32'({exec_gnt, ifu_gnt, mem_rd_req}), 32'b100);
      exec_wr_req = 1'b0;
      step();
      check("t2_c2_idle", 32'({mem_rd_req, mem_wr_req, ifu_gnt}), 32'd0);
      step();
      check("t2_c3_ifu_gnt", 32'(ifu_gnt), 32'd1);
      check("t2_c3_rd_req", 32'(mem_rd_req), 32'd1);
      check("t2_c3_rd_addr", 32'(mem_rd_addr), 32'o201);
      ifu_rd_req = 1'b0;
      step();
      check("t2_c4_valid", 32'(ifu_rd_valid), 32'd1);
      check("t2_c4_data", 32'(ifu_rd_data), 32'o4567);
      step();

      // Starvation guard: EXEC read held, fetch held
      exec_rd_req  = 1'b1;
      exec_rd_addr = 12'o0300;
      ifu_rd_req   = 1'b1;
      ifu_rd_addr  = 12'o0202;
      ngr = 0;
      for (int i = 0; i < 5; i++) gw[i] = 1'b0;
      for (int cyc = 0; cyc < 40 && ngr < 5; cyc++) begin
         step();
         if (exec_rd_valid) check("t3_exec_data", 32'(exec_rd_data), 32'o1111);
         if (ifu_gnt || exec_gnt) begin
            check("t3_gnt_onehot", 32'(ifu_gnt & exec_gnt), 32'd0);
            gw[ngr] = exec_gnt;
            ngr++;
         end
      end
      check("t3_grant_count", 32'(ngr), 32'd5);
      for (int i = 0; i < 4; i++) check("t3_exec_wins", 32'(gw[i]), 32'd1);
      check("t3_ifu_5th", 32'(gw[4]), 32'd0);
      ifu_rd_req  = 1'b0;
      exec_rd_req = 1'b0;
      step();
      check("t3_ifu_valid", 32'(ifu_rd_valid), 32'd1);
      check("t3_ifu_data", 32'(ifu_rd_data), 32'o2222);
      check("t3_cnt_clr", 32'(dut.starve_cnt), 32'd0);
      step();

      // EXEC read and write together
      check("t4_proto_pre", 32'(proto_err), 32'd0);
      exec_rd_req  = 1'b1;
      exec_rd_addr = 12'o0301;
      exec_wr_req  = 1'b1;
      exec_wr_addr = 12'o0051;
      exec_wr_data = 12'o0777;
      step();
      check("t4_wr_first", 32'({mem_wr_req, mem_rd_req, exec_gnt}), 32'b101);
      check("t4_wr_addr", 32'(mem_wr_addr), 32'o51);
      check("t4_proto_set", 32'(proto_err), 32'd1);
      exec_wr_req = 1'b0;
      step();
      check("t4_c2_gap", 32'({mem_wr_req, mem_rd_req}), 32'd0);
      step();
      check("t4_rd_issue", 32'({mem_rd_req, exec_gnt}), 32'b11);
      check("t4_rd_addr", 32'(mem_rd_addr), 32'o301);
      exec_rd_req = 1'b0;
      step();
      check("t4_rd_valid", 32'(exec_rd_valid), 32'd1);
      check("t4_rd_data", 32'(exec_rd_data), 32'o3333);
      step();
      step();
      check("t4_proto_sticky", 32'(proto_err), 32'd1);

      // Reset while a fetch read is in RD_ISSUE
      ifu_rd_req  = 1'b1;
      ifu_rd_addr = 12'o0203;
      step();
      check("t5_in_issue", 32'(mem_rd_req), 32'd1);
      reset = 1'b1;
      #1;
      check_quiet("t5_async");
      ifu_rd_req = 1'b0;
      step();
      reset = 1'b0;
      seen_valid = 1'b0;
      for (int cyc = 0; cyc < 3; cyc++) begin
         step();
         seen_valid = seen_valid | ifu_rd_valid | exec_rd_valid;
      end
      check("t5_no_valid", 32'(seen_valid), 32'd0);
      ifu_rd_req  = 1'b1;
      ifu_rd_addr = 12'o0204;
      step();
      check("t5_regrant", 32'({ifu_gnt, mem_rd_req}), 32'b11);
      check("t5_regrant_addr", 32'(mem_rd_addr), 32'o204);
      ifu_rd_req = 1'b0;
      step();
      check("t5_valid", 32'(ifu_rd_valid), 32'd1);
      check("t5_data", 32'(ifu_rd_data), 32'o6666);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
